// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;
  localparam int unsigned N_BITS = 32;
  localparam int unsigned ITERS  = 32;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned R_W    = N_BITS + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CALC   = 3'd3,
    DONE   = 3'd4
  } state_e;
endpackage

// File: rtl/div_seq_if.sv
// Handshake and result bus between a requester (master) and the divider (slave).
interface div_seq_if;
  import div_pkg::*;

  logic              start;
  logic [N_BITS-1:0] datain;
  logic [N_BITS-1:0] quotient;
  logic [N_BITS-1:0] remainder;
  logic              busy;
  logic              done;
  logic              div_by_zero;

  modport master (
    output start, datain,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, datain,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, compare, subtract.
module div_step
  import div_pkg::*;
(
  input  logic [R_W-1:0]    r_i,
  input  logic [N_BITS-1:0] q_i,
  input  logic [N_BITS-1:0] d_i,
  output logic [R_W-1:0]    r_o,
  output logic [N_BITS-1:0] q_o
);
  logic [R_W-1:0] t;
  logic [R_W-1:0] d_ext;
  logic           ge;

  always_comb begin
    // The top bit of R falls off the left shift; R stays below D between steps.
    t     = R_W'({r_i, q_i[N_BITS-1]});
    d_ext = {1'b0, d_i};
    ge    = (t >= d_ext);
    r_o   = ge ? (t - d_ext) : t;
    q_o   = {q_i[N_BITS-2:0], ge};
  end
endmodule

// File: rtl/div_seq.sv
// Sequential 32-bit unsigned divider, one quotient bit per cycle.
// Optional DIV_SEQ_DBZ_EN: a zero divisor short-circuits to DONE and raises div_by_zero.
module div_seq
  import div_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  div_seq_if.slave   bus
);
  state_e            state_q, state_d;
  logic [N_BITS-1:0] q_q, q_d;
  logic [R_W-1:0]    r_q, r_d;
  logic [N_BITS-1:0] d_q, d_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_BITS-1:0] quotient_q, quotient_d;
  logic [N_BITS-1:0] remainder_q, remainder_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef DIV_SEQ_DBZ_EN
  logic              dbz_flag_q, dbz_flag_d;
  logic              dbz_q, dbz_d;
`endif

  logic [R_W-1:0]    step_r;
  logic [N_BITS-1:0] step_q;

  div_step u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (step_r),
    .q_o (step_q)
  );

  // Next-state and datapath; outputs are a registered decode of the current state.
  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    r_d         = r_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef DIV_SEQ_DBZ_EN
    dbz_flag_d  = dbz_flag_q;
    dbz_d       = dbz_flag_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = LOAD_A;
      end
      LOAD_A: begin
        q_d     = bus.datain;
        state_d = LOAD_B;
      end
      LOAD_B: begin
        d_d     = bus.datain;
        r_d     = '0;
        cnt_d   = '0;
        state_d = CALC;
`ifdef DIV_SEQ_DBZ_EN
        if (bus.datain == '0) begin
          q_d        = '1;
          r_d        = R_W'(q_q);
          dbz_flag_d = 1'b1;
          state_d    = DONE;
        end
`endif
      end
      CALC: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERS - 1)) state_d = DONE;
      end
      DONE: begin
        quotient_d  = q_q;
        remainder_d = r_q[N_BITS-1:0];
        if (bus.start) begin
          state_d = LOAD_A;
`ifdef DIV_SEQ_DBZ_EN
          dbz_flag_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == CALC);
    done_d = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      q_q         <= '0;
      r_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DIV_SEQ_DBZ_EN
      dbz_flag_q  <= 1'b0;
      dbz_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      r_q         <= r_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef DIV_SEQ_DBZ_EN
      dbz_flag_q  <= dbz_flag_d;
      dbz_q       <= dbz_d;
`endif
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
`ifdef DIV_SEQ_DBZ_EN
  assign bus.div_by_zero = dbz_q;
`else
  assign bus.div_by_zero = 1'b0;
`endif
endmodule

// File: tb/tb_div_seq.sv
// Directed testbench for div_seq: vector table plus reset, back-to-back and start-toggle sequences.
module tb_div_seq;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lat;

  div_seq_if bus ();

  div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef DIV_SEQ_DBZ_EN
  localparam int   ZLAT = 3;
  localparam logic ZDBZ = 1'b1;
`else
  localparam int   ZLAT = 35;
  localparam logic ZDBZ = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Edge 0 samples start, edges 1/2 load the operands; lat is the edge index where done is first seen.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit toggle,
                         output int l);
    bus.start = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.datain = a;
    tick();
    check("busy_in_load", 32'(bus.busy), 32'd1);
    check("done_low_in_load", 32'(bus.done), 32'd0);
    bus.datain = b;
    l = -1;
    for (int k = 2; k <= 60; k++) begin
      tick();
      if (toggle && k < 30) bus.start = 1'($urandom_range(0, 1));
      else                  bus.start = 1'b0;
      if (bus.done) begin
        l = k;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 35};
    vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 35};
    vecs[2] = '{32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 35};
    vecs[3] = '{32'd42,         32'd0,          32'hFFFF_FFFF,  32'd42,         ZDBZ, ZLAT};
    vecs[4] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 35};
    vecs[5] = '{32'd1234567,    32'd1000,       32'd1234,       32'd567,        1'b0, 35};
    vecs[6] = '{32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          32'h7FFF_FFFE,  1'b0, 35};
    vecs[7] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 35};
    vecs[8] = '{32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFE,  1'b0, 35};

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.datain = '0;
    tick();
    tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_quotient", bus.quotient, 32'd0);
    check("rst_remainder", bus.remainder, 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_div(vecs[i].a, vecs[i].b, 1'b0, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_quotient", i), bus.quotient, vecs[i].q);
      check($sformatf("vec%0d_remainder", i), bus.remainder, vecs[i].r);
      check($sformatf("vec%0d_dbz", i), 32'(bus.div_by_zero), 32'(vecs[i].dbz));
    end

    // Results and done hold in DONE while start stays low.
    run_div(32'd100, 32'd7, 1'b0, lat);
    check("hold_latency", 32'(lat), 32'd35);
    repeat (3) tick();
    check("hold_done", 32'(bus.done), 32'd1);
    check("hold_quotient", bus.quotient, 32'd14);
    check("hold_remainder", bus.remainder, 32'd2);

    // Back-to-back from DONE: same latency as from IDLE means no IDLE cycle.
    run_div(32'd81, 32'd9, 1'b0, lat);
    check("b2b_latency", 32'(lat), 32'd35);
    check("b2b_quotient", bus.quotient, 32'd9);
    check("b2b_remainder", bus.remainder, 32'd0);

    // Reset in the 10th CALC cycle of 1000/3.
    bus.start = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.datain = 32'd1000;
    tick();
    bus.datain = 32'd3;
    for (int k = 2; k <= 12; k++) tick();
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_quotient", bus.quotient, 32'd0);
    check("midrst_remainder", bus.remainder, 32'd0);
    check("midrst_dbz", 32'(bus.div_by_zero), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_idle_busy", 32'(bus.busy), 32'd0);
    run_div(32'd1000, 32'd3, 1'b0, lat);
    check("after_rst_latency", 32'(lat), 32'd35);
    check("after_rst_quotient", bus.quotient, 32'd333);
    check("after_rst_remainder", bus.remainder, 32'd1);

    // start toggling during CALC must not disturb the operation.
    run_div(32'd100, 32'd7, 1'b1, lat);
    check("toggle_latency", 32'(lat), 32'd35);
    check("toggle_quotient", bus.quotient, 32'd14);
    check("toggle_remainder", bus.remainder, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request for a new division; sampled only in IDLE and DONE.
REQ-005 datain  input  32  serial operand bus: dividend in LOAD_A, divisor in LOAD_B.
REQ-006 quotient  output  32  registered quotient; valid while done=1.
REQ-007 remainder  output  32  registered remainder; valid while done=1.
REQ-008 busy  output  1  high in LOAD_A, LOAD_B and CALC.
REQ-009 done  output  1  high only in DONE.
REQ-010 div_by_zero  output  1  divisor-zero flag; the port is always present.
REQ-011 N_BITS, default 32, operand width; only 32 is supported.

Function
REQ-012 The FSM SHALL have the states IDLE, LOAD_A, LOAD_B, CALC and DONE, with all outputs registered.
REQ-013 IDLE with start=1 SHALL go to LOAD_A; IDLE with start=0 SHALL stay in IDLE.
REQ-014 LOAD_A SHALL capture datain into the dividend/Q register and go to LOAD_B unconditionally.
REQ-015 LOAD_B SHALL capture datain into the divisor register D, clear the 33-bit partial remainder R and the 5-bit iteration counter, and go to CALC.
REQ-016 Each CALC cycle SHALL form T={R[31:0],Q[31]}; if T>=D then R<=T-D and Q<={Q[30:0],1}, else R<=T and Q<={Q[30:0],0}.
REQ-017 The comparison and subtraction SHALL be unsigned and 33 bits wide, with no truncation of T.
REQ-018 CALC SHALL run exactly 32 cycles, leaving on counter wrap from 31 to DONE, where quotient<=Q and remainder<=R[31:0].
REQ-019 done SHALL rise on the 35th rising edge after the edge that samples start in IDLE.
REQ-020 DONE SHALL hold done and the results until start=1, which SHALL go to LOAD_A (back-to-back operation with no IDLE cycle).
REQ-021 start SHALL be ignored in LOAD_A, LOAD_B and CALC; an in-flight operation is never aborted by start.
REQ-022 A divisor of 0 without the feature in REQ-027 SHALL yield quotient=32'hFFFF_FFFF and remainder=dividend after 32 CALC cycles.
REQ-023 Dividend < divisor SHALL yield quotient=0 and remainder=dividend.

Reset
REQ-024 rst=1 SHALL force IDLE on the next edge from any state, including mid-CALC.
REQ-025 rst=1 SHALL clear quotient, remainder, busy, done, div_by_zero, Q, R, D and the counter to 0.
REQ-026 rst SHALL take priority over start on the same edge.

Configuration
REQ-027 Macro DIV_SEQ_DBZ_EN defined: in LOAD_B, datain==0 SHALL go directly to DONE with div_by_zero=1, quotient=32'hFFFF_FFFF and remainder=dividend.
REQ-028 In the DIV_SEQ_DBZ_EN case, done SHALL rise on the 3rd edge after the start sample.
REQ-029 div_by_zero SHALL clear when leaving DONE.
REQ-030 Macro DIV_SEQ_DBZ_EN undefined: div_by_zero SHALL be tied to 0 and zero divisors SHALL follow REQ-022.

Structure
REQ-031 Package div_pkg SHALL hold N_BITS, the state-encoding typedef (IDLE=0, LOAD_A=1, LOAD_B=2, CALC=3, DONE=4) and the iteration-count constant 32.
REQ-032 One combinational sub-module, div_step, SHALL implement REQ-016: inputs R, Q and D; outputs next R and next Q.
REQ-033 The FSM, counter and registers SHALL live in div_seq.

Verification
REQ-034 Stimulus: start, datain=100 then 7. Response: done on edge 35, quotient=14, remainder=2, div_by_zero=0.
REQ-035 Stimulus: datain=32'hFFFF_FFFF then 1. Response: quotient=32'hFFFF_FFFF, remainder=0. Stimulus: datain=5 then 9. Response: quotient=0, remainder=5.
REQ-036 Stimulus: datain=42 then 0. Response without the macro: done on edge 35, quotient=32'hFFFF_FFFF, remainder=42, div_by_zero=0. Response with the macro: done on edge 3, same results, div_by_zero=1.
REQ-037 Stimulus: rst=1 at CALC cycle 10 of 1000/3. Response: next edge IDLE with all outputs 0; a following 1000/3 gives 333 r 1.
REQ-038 Stimulus: in DONE of 100/7, assert start with datain=81 then 9. Response: busy next edge, no IDLE cycle, quotient=9, remainder=0.
REQ-039 Stimulus: toggle start during CALC. Response: no effect on cycle count or results.
